// File: rtl/serial_add_scheduler_if.sv
// ---------------------------------------------------------------------------
// serial_add_scheduler_if
//   Bundles the two parallel requester channels, the bit-serial adder link and
//   the result channel of serial_add_scheduler.
//
//   Handshake semantics (all channels): a transfer happens on the rising clock
//   edge where both vld and rdy are high. The producer holds its payload
//   stable while vld is high. rdy may depend combinationally on vld. A
//   producer may drop vld without a transfer.
//
//   Signals
//     req0_vld/req0_rdy/req0_a/req0_b : requester 0 operand pair
//     req1_vld/req1_rdy/req1_a/req1_b : requester 1 operand pair
//     stall                            : suppresses bit issue this cycle
//     add_vld/add_a/add_b/add_last     : bit stream towards the serial adder
//     add_sum                          : sum bit back from the serial adder
//     res_vld/res_rdy/res_id/res_data  : tagged W-bit result
//
//   Modports
//     master : the scheduler side
//     slave  : clients, adder and result consumer
// ---------------------------------------------------------------------------
interface serial_add_scheduler_if #(
  parameter int W = 8
);
  logic         req0_vld;
  logic         req0_rdy;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_vld;
  logic         req1_rdy;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         stall;
  logic         add_vld;
  logic         add_a;
  logic         add_b;
  logic         add_last;
  logic         add_sum;
  logic         res_vld;
  logic         res_rdy;
  logic         res_id;
  logic [W-1:0] res_data;

  modport master (
    input  req0_vld, req0_a, req0_b,
    output req0_rdy,
    input  req1_vld, req1_a, req1_b,
    output req1_rdy,
    input  stall,
    output add_vld, add_a, add_b, add_last,
    input  add_sum,
    output res_vld, res_id, res_data,
    input  res_rdy
  );

  modport slave (
    output req0_vld, req0_a, req0_b,
    input  req0_rdy,
    output req1_vld, req1_a, req1_b,
    input  req1_rdy,
    output stall,
    input  add_vld, add_a, add_b, add_last,
    output add_sum,
    input  res_vld, res_id, res_data,
    output res_rdy
  );
endinterface

// File: rtl/serial_add_scheduler.sv
// ---------------------------------------------------------------------------
// serial_add_scheduler
//   Shares one external bit-serial adder between two parallel requesters.
//   A round-robin arbiter accepts one W-bit operand pair at a time, streams it
//   LSB-first to the adder (add_vld/add_last framing), collects the returned
//   sum bits and presents a W-bit result tagged with the requester id.
//
//   Ports
//     clk         : clock, rising edge
//     rst_n       : asynchronous active-low reset
//     bus         : serial_add_scheduler_if.master (requests, adder link,
//                   result channel)
//     o_dbg_state : current FSM state (0 idle, 1 shift, 2 resp)
//
//   Timing with no stall and res_rdy high: accept at cycle 0, bits at cycles
//   1..W, result valid at cycle W+1, next accept at cycle W+2.
// ---------------------------------------------------------------------------
module serial_add_scheduler #(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_add_scheduler_if.master bus,
  output logic [1:0]             o_dbg_state
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_ptr;     // preferred requester when both are valid
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic [CW-1:0]  r_cnt;
  logic           r_id;

  logic w_idle;
  logic w_any_req;
  logic w_gnt_id;
  logic w_hs;
  logic w_issue;
  logic w_last_bit;

  // ---------------------------------------------------------------------
  // Arbitration. rdy is combinational and gated with rst_n so that both
  // rdy outputs read 0 throughout reset even with requests pending.
  // ---------------------------------------------------------------------
  assign w_idle    = rst_n && (r_state == S_IDLE);
  assign w_any_req = bus.req0_vld || bus.req1_vld;
  assign w_gnt_id  = (bus.req0_vld && bus.req1_vld) ? r_ptr : bus.req1_vld;
  assign w_hs      = w_idle && w_any_req;

  assign bus.req0_rdy = w_hs && !w_gnt_id;
  assign bus.req1_rdy = w_hs &&  w_gnt_id;

  // ---------------------------------------------------------------------
  // Bit issue. A stalled cycle leaves every register untouched, so the
  // counter only advances on cycles that really hand a bit to the adder.
  // ---------------------------------------------------------------------
  assign w_issue    = (r_state == S_SHIFT) && !bus.stall;
  assign w_last_bit = (r_cnt == CW'(W - 1));

  assign bus.add_vld  = w_issue;
  assign bus.add_last = w_issue && w_last_bit;
  assign bus.add_a    = (r_state == S_SHIFT) ? r_a[0] : 1'b0;
  assign bus.add_b    = (r_state == S_SHIFT) ? r_b[0] : 1'b0;

  assign bus.res_vld  = (r_state == S_RESP);
  assign bus.res_id   = r_id;
  assign bus.res_data = r_sum;

  assign o_dbg_state  = r_state;

  // ---------------------------------------------------------------------
  // Control FSM and datapath registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_id    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_a     <= w_gnt_id ? bus.req1_a : bus.req0_a;
            r_b     <= w_gnt_id ? bus.req1_b : bus.req0_b;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_id    <= w_gnt_id;
            // Next contention goes to the requester that was not just served.
            r_ptr   <= ~w_gnt_id;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_issue) begin
            // Sum bits arrive LSB first; after W shifts bit 0 sits at r_sum[0].
            r_sum <= {bus.add_sum, r_sum[W-1:1]};
            r_a   <= {1'b0, r_a[W-1:1]};
            r_b   <= {1'b0, r_b[W-1:1]};
            r_cnt <= r_cnt + CW'(1);
            if (w_last_bit) begin
              r_state <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (bus.res_rdy) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// ---------------------------------------------------------------------------
// tb_serial_add_scheduler
//   Directed bench for serial_add_scheduler. Contains a bit-serial adder model
//   sharing the DUT reset. A table of operations (requests, stall pattern,
//   expected grant and result) is applied in a loop; hand-written sequences
//   cover result backpressure and reset in the middle of a shift.
// ---------------------------------------------------------------------------
module tb_serial_add_scheduler;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  serial_add_scheduler_if #(.W(W)) bus ();

  serial_add_scheduler #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- serial adder model ----------------
  logic carry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            carry <= 1'b0;
    else if (bus.add_vld)  carry <= bus.add_last ? 1'b0 :
                                    ((bus.add_a & bus.add_b) | (bus.add_a & carry) | (bus.add_b & carry));
  end
  assign bus.add_sum = bus.add_a ^ bus.add_b ^ carry;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         v0;
    logic         v1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [15:0]  stall_mask;  // bit k stalls the k-th cycle after accept
    int           exp_cyc;     // cycles from first shift cycle to res_vld
    logic         exp_id;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  // Called just after a falling edge. Presents the request, waits for the
  // grant, follows the bit stream and returns while res_vld is sampled high.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic [15:0] mask, input int exp_cyc,
                        input logic exp_id, input logic [W-1:0] exp_data,
                        input string tag);
    int n, k, pulses, lasts, last_pulse, bad_bits;
    logic done;
    logic [W-1:0] ea, eb;
    ea = exp_id ? a1 : a0;
    eb = exp_id ? b1 : b0;
    bus.req0_vld = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_vld = v1; bus.req1_a = a1; bus.req1_b = b1;
    #1;
    n = 0;
    while (!(bus.req0_rdy || bus.req1_rdy) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, " grant_seen"}, {31'd0, bus.req0_rdy | bus.req1_rdy}, 32'd1);
    check({tag, " grant_wait"}, n, 0);
    check({tag, " rdy_onehot"}, {31'd0, bus.req0_rdy & bus.req1_rdy}, 32'd0);
    check({tag, " grant_id"}, {31'd0, bus.req1_rdy}, {31'd0, exp_id});
    @(negedge clk);
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    pulses = 0; lasts = 0; last_pulse = -1; bad_bits = 0; k = 0; done = 1'b0;
    while (!done && k < 40) begin
      bus.stall = (k < 16) ? mask[k] : 1'b0;
      #1;
      if (bus.res_vld) begin
        done = 1'b1;
      end else begin
        if (bus.add_vld) begin
          if (pulses < W && (bus.add_a !== ea[pulses] || bus.add_b !== eb[pulses])) bad_bits++;
          if (bus.add_last) begin
            lasts++;
            last_pulse = pulses;
          end
          pulses++;
        end else if (bus.add_last) begin
          lasts += 100;
        end
        @(negedge clk);
        k++;
      end
    end
    bus.stall = 1'b0;
    check({tag, " res_vld_seen"}, {31'd0, done}, 32'd1);
    check({tag, " res_cycle"}, k, exp_cyc);
    check({tag, " vld_pulses"}, pulses, W);
    check({tag, " last_count"}, lasts, 1);
    check({tag, " last_pos"}, last_pulse, W - 1);
    check({tag, " operand_bits"}, bad_bits, 0);
    check({tag, " res_data"}, {24'd0, bus.res_data}, {24'd0, exp_data});
    check({tag, " res_id"}, {31'd0, bus.res_id}, {31'd0, exp_id});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    //          v0    v1    a0     b0     a1     b1     stall   cyc id    data
    vecs[0]  = '{1'b1, 1'b0, 8'h35, 8'h4A, 8'h00, 8'h00, 16'h00, 8,  1'b0, 8'h7F};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h01, 16'h00, 8,  1'b1, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'h01, 16'h00, 8,  1'b1, 8'h02};
    vecs[3]  = '{1'b1, 1'b1, 8'h10, 8'h20, 8'h03, 8'h04, 16'h00, 8,  1'b0, 8'h30};
    vecs[4]  = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h05, 8'h06, 16'h00, 8,  1'b1, 8'h0B};
    vecs[5]  = '{1'b1, 1'b1, 8'h80, 8'h80, 8'h7F, 8'h7F, 16'h00, 8,  1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 8'h01, 8'h01, 8'hAA, 8'h55, 16'h00, 8,  1'b1, 8'hFF};
    vecs[7]  = '{1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 16'h00, 8,  1'b0, 8'h03};
    vecs[8]  = '{1'b1, 1'b0, 8'h0C, 8'h0C, 8'h00, 8'h00, 16'h00, 8,  1'b0, 8'h18};
    vecs[9]  = '{1'b1, 1'b0, 8'h0F, 8'h01, 8'h00, 8'h00, 16'h48, 10, 1'b0, 8'h10};
    vecs[10] = '{1'b1, 1'b1, 8'h09, 8'h09, 8'h40, 8'h3F, 16'h00, 8,  1'b1, 8'h7F};

    bus.req0_vld = 1'b1; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
    bus.req1_vld = 1'b1; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    bus.stall    = 1'b0;
    bus.res_rdy  = 1'b1;

    // Reset state with both requests pending.
    #2;
    check("rst req0_rdy", {31'd0, bus.req0_rdy}, 32'd0);
    check("rst req1_rdy", {31'd0, bus.req1_rdy}, 32'd0);
    check("rst add_vld",  {31'd0, bus.add_vld},  32'd0);
    check("rst add_last", {31'd0, bus.add_last}, 32'd0);
    check("rst res_vld",  {31'd0, bus.res_vld},  32'd0);
    check("rst res_id",   {31'd0, bus.res_id},   32'd0);
    check("rst res_data", {24'd0, bus.res_data}, 32'd0);
    check("rst state",    {30'd0, dbg_state},    32'd0);
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven operations.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
             vecs[i].stall_mask, vecs[i].exp_cyc, vecs[i].exp_id, vecs[i].exp_data,
             $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Backpressure: result held for 5 cycles with a request pending.
    bus.res_rdy = 1'b0;
    run_op(1'b1, 1'b0, 8'h21, 8'h13, 8'h00, 8'h00, 16'h00, 8, 1'b0, 8'h34, "bp");
    bus.req0_vld = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("bp hold%0d res_vld", i),  {31'd0, bus.res_vld},  32'd1);
      check($sformatf("bp hold%0d res_data", i), {24'd0, bus.res_data}, 32'h34);
      check($sformatf("bp hold%0d res_id", i),   {31'd0, bus.res_id},   32'd0);
      check($sformatf("bp hold%0d req0_rdy", i), {31'd0, bus.req0_rdy}, 32'd0);
    end
    @(negedge clk);
    bus.res_rdy = 1'b1;
    #1;
    check("bp release req0_rdy", {31'd0, bus.req0_rdy}, 32'd0);
    @(negedge clk);
    run_op(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 16'h00, 8, 1'b0, 8'h02, "bp_next");
    @(negedge clk);

    // Reset in the middle of a shift, pointer left at requester 1 beforehand.
    bus.req0_vld = 1'b1; bus.req0_a = 8'h55; bus.req0_b = 8'h22;
    #1;
    check("mid req0_rdy", {31'd0, bus.req0_rdy}, 32'd1);
    @(negedge clk);
    bus.req0_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid add_vld before rst", {31'd0, bus.add_vld}, 32'd1);
    bus.req0_vld = 1'b1; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
    bus.req1_vld = 1'b1; bus.req1_a = 8'h77; bus.req1_b = 8'h01;
    rst_n = 1'b0;
    #1;
    check("mid rst add_vld",  {31'd0, bus.add_vld},  32'd0);
    check("mid rst add_last", {31'd0, bus.add_last}, 32'd0);
    check("mid rst res_vld",  {31'd0, bus.res_vld},  32'd0);
    check("mid rst req0_rdy", {31'd0, bus.req0_rdy}, 32'd0);
    check("mid rst req1_rdy", {31'd0, bus.req1_rdy}, 32'd0);
    check("mid rst state",    {30'd0, dbg_state},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 1'b1, 8'h12, 8'h34, 8'h77, 8'h01, 16'h00, 8, 1'b0, 8'h46, "post_rst");
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
- Shares one external bit-serial adder between two parallel requesters.
- Arbitrates round-robin and accepts one W-bit operand pair.
- Streams the pair LSB-first into the adder with vld/last framing, gathers the sum bits, and returns a W-bit result tagged with the requester ID.
- Sits between parallel client logic and the serial adder datapath.

Parameters:
W, 8, operand/result width in bits (W >= 2).

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req0_vld  input  1  requester 0 has an operand pair
req0_rdy  output  1  requester 0 pair accepted this cycle when req0_vld is also high
req0_a  input  W  requester 0 operand A
req0_b  input  W  requester 0 operand B
req1_vld  input  1  requester 1 has an operand pair
req1_rdy  output  1  requester 1 accept
req1_a  input  W  requester 1 operand A
req1_b  input  W  requester 1 operand B
stall  input  1  suppresses bit issue this cycle
add_vld  output  1  serial adder bit valid
add_a  output  1  serial adder A bit
add_b  output  1  serial adder B bit
add_last  output  1  final bit of the current word
add_sum  input  1  serial adder sum bit, combinational from the adder's current-cycle inputs
res_vld  output  1  result available
res_rdy  input  1  consumer takes the result when res_vld is also high
res_id  output  1  requester that owns the result
res_data  output  W  sum modulo 2^W

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - State goes to IDLE. The round-robin pointer prefers requester 0.
  - All outputs are 0 while rst_n is low: rdy, add_*, res_vld, res_id, res_data.
  - An in-flight operation is dropped silently and add_vld falls immediately.
  - The adder must share this reset so its carry clears.
- States:
  - IDLE: wait for a request.
  - SHIFT: issue operand bits.
  - RESP: hold the result.
- IDLE:
  - reqN_rdy is high combinationally only for the granted requester, and only in IDLE.
  - The two rdy signals are never high together.
  - Grant with one request valid: that requester.
  - Grant with both valid: the requester not granted most recently.
  - The pointer updates only on an accepted handshake.
  - On handshake: capture a and b into shift registers, clear the bit counter and the sum register, latch res_id, go to SHIFT.
- SHIFT:
  - Each cycle with stall=0: add_vld=1, add_a/add_b = current LSBs, add_sum shifted into the MSB of the sum register, operands shifted right, counter incremented.
  - add_last=1 only on the bit where counter==W-1, and only with add_vld=1.
  - With stall=1: add_vld=add_last=0 and nothing changes. add_a/add_b still show the current bits but are don't-care.
  - After the last bit issues, go to RESP.
  - Exactly W add_vld pulses per operation and exactly one add_last.
- RESP:
  - res_vld=1. res_data and res_id stay stable until res_rdy.
  - On res_vld&&res_rdy go to IDLE. A new grant is possible the following cycle.
  - No request is accepted while in RESP.
- Timing with no stalls and res_rdy held high:
  - Handshake at cycle 0; bits at cycles 1..W; res_vld at cycle W+1; next accept at cycle W+2.
  - Minimum period is W+2 cycles per operation.
- Arithmetic: carry out of bit W-1 is discarded (wraps modulo 2^W).
- Boundaries:
  - Request inputs are ignored outside IDLE.
  - A requester dropping vld without a handshake is not an error.
  - stall is ignored in IDLE and RESP.

Test Plan:
- Single operation: req0 a=0x35 b=0x4A, no stall -> add_vld for 8 cycles; add_last on the 8th only; res_vld at cycle 9 with res_data=0x7F, res_id=0.
- Overflow: req1 a=0xFF b=0x01 -> res_data=0x00, res_id=1. A following req1 0x01+0x01 gives 0x02, proving the carry cleared.
- Contention:
  - req0 and req1 valid together in every IDLE -> grants alternate 0,1,0,1 starting at 0 after reset.
  - req0 alone twice -> granted 0 twice.
- Stall: a=0x0F b=0x01 with stall high on bits 3 and 6 -> 8 add_vld pulses spread over 10 cycles; add_last only on the real 8th bit; result 0x10.
- Backpressure: res_rdy low for 5 cycles -> res_vld, res_data and res_id stable; req_rdy stays low; accept resumes the cycle after res_rdy.
- Reset mid-SHIFT: rst_n low after 3 bits -> add_vld=0 and res_vld=0 immediately. After release, 0x12+0x34 returns 0x46 with the grant pointer back at requester 0.
